// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch/jump redirect
// and a multi-cycle mult/div busy tracker that holds HI/LO consumers in ID.
module pipe_hazard_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             uses_rt_id,
    input  logic             hilo_use_id,
    input  logic             mem_read_ex,
    input  logic [4:0]       num_write_ex,
    input  logic             md_start_ex,
    input  logic             branch_taken_ex,
    input  logic             jump_id,
    output logic             pc_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EXE_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    // state | meaning
    // IDLE  | mult/div unit free
    // BUSY  | mult/div running, md_cnt counts down to the final cycle
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MD_W = 8;

    state_t           state, state_nxt;
    logic [MD_W-1:0]  md_cnt, md_cnt_nxt;
    logic [CNT_W-1:0] stall_q;
    logic             md_last;
    logic             lu, mdh, stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            md_cnt  <= '0;
            stall_q <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (pc_stall && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign md_last = (state == BUSY) && (md_cnt == '0);

    // md_start_ex during BUSY cannot happen since the issuing instruction sits stalled in ID.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            IDLE: begin
                if (md_start_ex) begin
                    state_nxt  = BUSY;
                    md_cnt_nxt = MD_W'(MD_CYCLES - 1);
                end
            end
            BUSY: begin
                if (md_last)
                    state_nxt = IDLE;
                else
                    md_cnt_nxt = md_cnt - 1'b1;
            end
            default: begin
                state_nxt  = IDLE;
                md_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        lu = mem_read_ex && (num_write_ex != 5'd0) &&
             ((num_write_ex == rs_id) || (uses_rt_id && (num_write_ex == rt_id)));
        // The final busy cycle already releases ID so the consumer issues on the next edge.
        mdh   = hilo_use_id && (state == BUSY) && !md_last;
        stall = lu || mdh;
    end

    always_comb begin
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EXE_flush = 1'b0;
        if (!reset) begin
            if (branch_taken_ex) begin
                IF_ID_flush  = 1'b1;
                ID_EXE_flush = 1'b1;
            end else if (stall) begin
                pc_stall     = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EXE_flush = 1'b1;
            end else if (jump_id) begin
                IF_ID_flush = 1'b1;
            end
        end
    end

    assign md_busy      = !reset && (state == BUSY);
    assign md_done      = !reset && md_last;
    assign stall_cycles = reset ? '0 : stall_q;

endmodule
